// File: rtl/fpu_issue_ctl.sv
// fpu_issue_ctl: core-side issue/writeback sequencer for the FpuFpD datapath.
// Holds one FPU command stable for its latency, captures the FPU result and
// control outputs, then strobes one FPR writeback plus a control-reg commit.
// Optional feature macro: FPU_ISSUE_BYPASS_EN. When defined, exHold drops in
// the writeback cycle so a follow-on command can be accepted then, and the
// result being written back is forwarded into that command's operands.
module fpu_issue_ctl #(
   parameter int unsigned LAT_ADD = 3,
   parameter int unsigned LAT_MUL = 3,
   parameter int unsigned LAT_CNV = 2,
   parameter int unsigned LAT_DEF = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exValid,
   input  logic [7:0]  exOpMode,
   input  logic [1:0]  exIdMode,
   input  logic [6:0]  exRegA,
   input  logic [6:0]  exRegB,
   input  logic [6:0]  exRegC,
   input  logic [63:0] exValA,
   input  logic [63:0] exValB,
   input  logic [63:0] exValC,
   input  logic [31:0] exSr,
   input  logic [31:0] exFpul,
   input  logic [31:0] exFpScr,
   output logic        exHold,
   output logic [7:0]  fpuOpMode,
   output logic [1:0]  fpuIdMode,
   output logic [6:0]  fpuRegA,
   output logic [6:0]  fpuRegB,
   output logic [6:0]  fpuRegC,
   output logic [63:0] fpuValA,
   output logic [63:0] fpuValB,
   output logic [63:0] fpuValC,
   output logic [31:0] fpuSr,
   output logic [31:0] fpuFpul,
   output logic [31:0] fpuFpScr,
   input  logic [6:0]  fpuRegD,
   input  logic [63:0] fpuValD,
   input  logic [1:0]  fpuModeD,
   input  logic [31:0] fpuOutSr,
   input  logic [31:0] fpuOutFpul,
   input  logic [31:0] fpuOutFpScr,
   output logic        wbEn,
   output logic [6:0]  wbReg,
   output logic [63:0] wbVal,
   output logic [1:0]  wbMode,
   output logic        ctlWe,
   output logic [31:0] ctlOutSr,
   output logic [31:0] ctlOutFpul,
   output logic [31:0] ctlOutFpScr,
   output logic [1:0]  dbg_state
);

   // Opcode and register encodings shared with the core decoder.
   localparam logic [7:0] UCMD_FPU_NONE  = 8'h00;
   localparam logic [7:0] UCMD_FPU_ADD   = 8'h01;
   localparam logic [7:0] UCMD_FPU_SUB   = 8'h02;
   localparam logic [7:0] UCMD_FPU_MUL   = 8'h03;
   localparam logic [7:0] UCMD_FPU_MAC   = 8'h04;
   localparam logic [7:0] UCMD_FPU_MSC   = 8'h05;
   localparam logic [7:0] UCMD_FPU_CNVSI = 8'h06;
   localparam logic [7:0] UCMD_FPU_CNVIS = 8'h07;
   localparam logic [6:0] UREG_ZZR       = 7'h00;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_WB = 2'd2} state_t;

   typedef struct packed {
      logic [7:0]  op;
      logic [1:0]  mode;
      logic [6:0]  ra;
      logic [6:0]  rb;
      logic [6:0]  rc;
      logic [63:0] va;
      logic [63:0] vb;
      logic [63:0] vc;
      logic [31:0] sr;
      logic [31:0] fpul;
      logic [31:0] fpscr;
   } cmd_t;

   typedef struct packed {
      logic [6:0]  rd;
      logic [63:0] vd;
      logic [1:0]  md;
      logic [31:0] sr;
      logic [31:0] fpul;
      logic [31:0] fpscr;
   } res_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   cmd_t       cmd_q, cmd_d, new_cmd;
   res_t       res_q, res_d;
   logic       wb_en_q, wb_en_d;
   logic       ctl_we_q, ctl_we_d;
   logic       fwd_ok;
   logic       accept;

   // Run length minus one, so the count reaches zero in the last RUN cycle.
   function automatic logic [3:0] lat_m1(input logic [7:0] op);
      case (op)
         UCMD_FPU_ADD, UCMD_FPU_SUB,
         UCMD_FPU_MAC, UCMD_FPU_MSC:     lat_m1 = 4'(LAT_ADD - 1);
         UCMD_FPU_MUL:                   lat_m1 = 4'(LAT_MUL - 1);
         UCMD_FPU_CNVSI, UCMD_FPU_CNVIS: lat_m1 = 4'(LAT_CNV - 1);
         default:                        lat_m1 = 4'(LAT_DEF - 1);
      endcase
   endfunction

   // Handshake: a command transfers at a rising edge when exValid is high,
   // exOpMode is not NONE and exHold is low; while exHold is high the core
   // keeps its command stable. A NONE opcode never transfers.
`ifdef FPU_ISSUE_BYPASS_EN
   assign exHold = (state_q == ST_RUN);
`else
   assign exHold = (state_q != ST_IDLE);
`endif
   assign accept = exValid && (exOpMode != UCMD_FPU_NONE) && !exHold;

   // Build the command to latch, forwarding the result still being written back.
   always_comb begin
      fwd_ok = 1'b0;
`ifdef FPU_ISSUE_BYPASS_EN
      fwd_ok = (state_q == ST_WB);
`endif
      new_cmd.op    = exOpMode;
      new_cmd.mode  = exIdMode;
      new_cmd.ra    = exRegA;
      new_cmd.rb    = exRegB;
      new_cmd.rc    = exRegC;
      new_cmd.va    = (fwd_ok && wb_en_q && exRegA == res_q.rd) ? res_q.vd : exValA;
      new_cmd.vb    = (fwd_ok && wb_en_q && exRegB == res_q.rd) ? res_q.vd : exValB;
      new_cmd.vc    = (fwd_ok && wb_en_q && exRegC == res_q.rd) ? res_q.vd : exValC;
      new_cmd.sr    = fwd_ok ? res_q.sr    : exSr;
      new_cmd.fpul  = fwd_ok ? res_q.fpul  : exFpul;
      new_cmd.fpscr = fwd_ok ? res_q.fpscr : exFpScr;
   end

   // Next-state logic: count down the run, capture results, one-cycle writeback.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cmd_d    = cmd_q;
      res_d    = res_q;
      wb_en_d  = 1'b0;
      ctl_we_d = 1'b0;
      case (state_q)
         ST_IDLE: ;
         ST_RUN: begin
            if (cnt_q == 4'd0) begin
               res_d.rd    = fpuRegD;
               res_d.vd    = fpuValD;
               res_d.md    = fpuModeD;
               res_d.sr    = fpuOutSr;
               res_d.fpul  = fpuOutFpul;
               res_d.fpscr = fpuOutFpScr;
               wb_en_d     = (fpuRegD != UREG_ZZR);
               ctl_we_d    = 1'b1;
               state_d     = ST_WB;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         cmd_d   = new_cmd;
         cnt_d   = lat_m1(exOpMode);
         state_d = ST_RUN;
      end
   end

   // State and holding registers; reset discards any in-flight command.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         cmd_q    <= '0;
         res_q    <= '0;
         wb_en_q  <= 1'b0;
         ctl_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         res_q    <= res_d;
         wb_en_q  <= wb_en_d;
         ctl_we_q <= ctl_we_d;
      end
   end

   assign fpuOpMode   = (state_q == ST_IDLE) ? UCMD_FPU_NONE : cmd_q.op;
   assign fpuIdMode   = cmd_q.mode;
   assign fpuRegA     = cmd_q.ra;
   assign fpuRegB     = cmd_q.rb;
   assign fpuRegC     = cmd_q.rc;
   assign fpuValA     = cmd_q.va;
   assign fpuValB     = cmd_q.vb;
   assign fpuValC     = cmd_q.vc;
   assign fpuSr       = cmd_q.sr;
   assign fpuFpul     = cmd_q.fpul;
   assign fpuFpScr    = cmd_q.fpscr;
   assign wbEn        = wb_en_q;
   assign wbReg       = res_q.rd;
   assign wbVal       = res_q.vd;
   assign wbMode      = res_q.md;
   assign ctlWe       = ctl_we_q;
   assign ctlOutSr    = res_q.sr;
   assign ctlOutFpul  = res_q.fpul;
   assign ctlOutFpScr = res_q.fpscr;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_fpu_issue_ctl.sv
// tb_fpu_issue_ctl: directed bench for fpu_issue_ctl with a cycle-count
// transaction model and per-cycle output comparison.
module tb_fpu_issue_ctl;

   localparam logic [7:0] OP_NONE  = 8'h00;
   localparam logic [7:0] OP_ADD   = 8'h01;
   localparam logic [7:0] OP_SUB   = 8'h02;
   localparam logic [7:0] OP_MUL   = 8'h03;
   localparam logic [7:0] OP_MAC   = 8'h04;
   localparam logic [7:0] OP_MSC   = 8'h05;
   localparam logic [7:0] OP_CNVSI = 8'h06;
   localparam logic [7:0] OP_CNVIS = 8'h07;
   localparam logic [7:0] OP_CMPEQ = 8'h08;
   localparam logic [7:0] OP_MOV   = 8'h0A;
   localparam logic [6:0] ZZR      = 7'h00;
`ifdef FPU_ISSUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk, reset, exValid, exHold, wbEn, ctlWe;
   logic [7:0]  exOpMode, fpuOpMode;
   logic [1:0]  exIdMode, fpuIdMode, fpuModeD, wbMode, dbg_state;
   logic [6:0]  exRegA, exRegB, exRegC, fpuRegA, fpuRegB, fpuRegC, fpuRegD, wbReg;
   logic [63:0] exValA, exValB, exValC, fpuValA, fpuValB, fpuValC, fpuValD, wbVal;
   logic [31:0] exSr, exFpul, exFpScr, fpuSr, fpuFpul, fpuFpScr;
   logic [31:0] fpuOutSr, fpuOutFpul, fpuOutFpScr, ctlOutSr, ctlOutFpul, ctlOutFpScr;

   fpu_issue_ctl dut (
      .clk(clk), .reset(reset), .exValid(exValid), .exOpMode(exOpMode), .exIdMode(exIdMode),
      .exRegA(exRegA), .exRegB(exRegB), .exRegC(exRegC),
      .exValA(exValA), .exValB(exValB), .exValC(exValC),
      .exSr(exSr), .exFpul(exFpul), .exFpScr(exFpScr), .exHold(exHold),
      .fpuOpMode(fpuOpMode), .fpuIdMode(fpuIdMode),
      .fpuRegA(fpuRegA), .fpuRegB(fpuRegB), .fpuRegC(fpuRegC),
      .fpuValA(fpuValA), .fpuValB(fpuValB), .fpuValC(fpuValC),
      .fpuSr(fpuSr), .fpuFpul(fpuFpul), .fpuFpScr(fpuFpScr),
      .fpuRegD(fpuRegD), .fpuValD(fpuValD), .fpuModeD(fpuModeD),
      .fpuOutSr(fpuOutSr), .fpuOutFpul(fpuOutFpul), .fpuOutFpScr(fpuOutFpScr),
      .wbEn(wbEn), .wbReg(wbReg), .wbVal(wbVal), .wbMode(wbMode), .ctlWe(ctlWe),
      .ctlOutSr(ctlOutSr), .ctlOutFpul(ctlOutFpul), .ctlOutFpScr(ctlOutFpScr),
      .dbg_state(dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   typedef struct {
      logic [7:0]  op;
      logic [1:0]  mode;
      logic [6:0]  ra, rb, rc;
      logic [63:0] va, vb, vc;
      logic [31:0] sr, fpul, fpscr;
   } cmd_t;

   cmd_t        m_cmd;
   bit          m_on = 1'b0;
   bit          m_busy = 1'b0;
   int          m_acc = 0;
   int          m_lat = 1;
   int          mdl_cyc = 0;
   logic [6:0]  r_reg;
   logic [63:0] r_val;
   logic [1:0]  r_mode;
   logic [31:0] r_sr, r_fpul, r_fpscr;

   function automatic int lat_of(input logic [7:0] op);
      if (op == OP_ADD || op == OP_SUB || op == OP_MAC || op == OP_MSC) return 3;
      if (op == OP_MUL) return 3;
      if (op == OP_CNVSI || op == OP_CNVIS) return 2;
      return 1;
   endfunction

   // Model: an accepted op runs for LAT cycles, its result is taken in the
   // last run cycle and written back in the cycle after.
   always @(posedge clk) begin
      int rel;
      bit in_wb, can_acc, fwd;
      if (reset) begin
         m_on = 1'b1; m_busy = 1'b0; m_acc = 0; m_lat = 1;
         m_cmd = '{op: 8'h0, mode: 2'h0, ra: 7'h0, rb: 7'h0, rc: 7'h0,
                   va: 64'h0, vb: 64'h0, vc: 64'h0, sr: 32'h0, fpul: 32'h0, fpscr: 32'h0};
         r_reg = 7'h0; r_val = 64'h0; r_mode = 2'h0;
         r_sr = 32'h0; r_fpul = 32'h0; r_fpscr = 32'h0;
      end else if (m_on) begin
         rel     = mdl_cyc - m_acc;
         in_wb   = m_busy && (rel == m_lat + 1);
         can_acc = !m_busy || (BYP && in_wb);
         if (m_busy && rel == m_lat) begin
            r_reg = fpuRegD; r_val = fpuValD; r_mode = fpuModeD;
            r_sr = fpuOutSr; r_fpul = fpuOutFpul; r_fpscr = fpuOutFpScr;
         end
         if (in_wb) m_busy = 1'b0;
         if (exValid && exOpMode != OP_NONE && can_acc) begin
            fwd = BYP && in_wb && (r_reg != ZZR);
            m_cmd.op = exOpMode; m_cmd.mode = exIdMode;
            m_cmd.ra = exRegA; m_cmd.rb = exRegB; m_cmd.rc = exRegC;
            m_cmd.va = (fwd && exRegA == r_reg) ? r_val : exValA;
            m_cmd.vb = (fwd && exRegB == r_reg) ? r_val : exValB;
            m_cmd.vc = (fwd && exRegC == r_reg) ? r_val : exValC;
            m_cmd.sr    = (BYP && in_wb) ? r_sr    : exSr;
            m_cmd.fpul  = (BYP && in_wb) ? r_fpul  : exFpul;
            m_cmd.fpscr = (BYP && in_wb) ? r_fpscr : exFpScr;
            m_acc = mdl_cyc; m_lat = lat_of(exOpMode); m_busy = 1'b1;
         end
      end
      mdl_cyc++;
   end

   // Compare process: every cycle after reset has been seen.
   always @(negedge clk) begin
      int rel;
      bit run, wb;
      if (m_on) begin
         rel = mdl_cyc - m_acc;
         run = m_busy && rel >= 1 && rel <= m_lat;
         wb  = m_busy && rel == m_lat + 1;
         chk("m_exHold", 64'(exHold), 64'(run || (wb && !BYP)));
         chk("m_wbEn", 64'(wbEn), 64'(wb && r_reg != ZZR));
         chk("m_ctlWe", 64'(ctlWe), 64'(wb));
         chk("m_wbReg", 64'(wbReg), 64'(r_reg));
         chk("m_wbVal", wbVal, r_val);
         chk("m_wbMode", 64'(wbMode), 64'(r_mode));
         chk("m_ctlOutSr", 64'(ctlOutSr), 64'(r_sr));
         chk("m_ctlOutFpul", 64'(ctlOutFpul), 64'(r_fpul));
         chk("m_ctlOutFpScr", 64'(ctlOutFpScr), 64'(r_fpscr));
         if (!m_busy) chk("m_fpuOpMode_idle", 64'(fpuOpMode), 64'(OP_NONE));
         if (run) begin
            chk("m_fpuOpMode", 64'(fpuOpMode), 64'(m_cmd.op));
            chk("m_fpuIdMode", 64'(fpuIdMode), 64'(m_cmd.mode));
            chk("m_fpuRegA", 64'(fpuRegA), 64'(m_cmd.ra));
            chk("m_fpuRegB", 64'(fpuRegB), 64'(m_cmd.rb));
            chk("m_fpuRegC", 64'(fpuRegC), 64'(m_cmd.rc));
            chk("m_fpuValA", fpuValA, m_cmd.va);
            chk("m_fpuValB", fpuValB, m_cmd.vb);
            chk("m_fpuValC", fpuValC, m_cmd.vc);
            chk("m_fpuSr", 64'(fpuSr), 64'(m_cmd.sr));
            chk("m_fpuFpul", 64'(fpuFpul), 64'(m_cmd.fpul));
            chk("m_fpuFpScr", 64'(fpuFpScr), 64'(m_cmd.fpscr));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input logic [7:0] op, input logic [1:0] md,
                            input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                            input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                            input logic [31:0] sr);
      exValid = 1'b1; exOpMode = op; exIdMode = md;
      exRegA = ra; exRegB = rb; exRegC = rc;
      exValA = va; exValB = vb; exValC = vc;
      exSr = sr; exFpul = sr ^ 32'h0F0F_0000; exFpScr = sr + 32'd7;
   endtask

   task automatic clr_cmd();
      exValid = 1'b0; exOpMode = OP_NONE;
   endtask

   task automatic set_resp(input logic [6:0] rd, input logic [63:0] vd, input logic [1:0] md,
                           input logic [31:0] sr);
      fpuRegD = rd; fpuValD = vd; fpuModeD = md;
      fpuOutSr = sr; fpuOutFpul = sr + 32'd1; fpuOutFpScr = ~sr;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int acc3, wb3, acc4;
   logic [7:0] op_list[6];

   initial begin
      reset = 1'b1;
      exValid = 1'b0; exOpMode = OP_NONE; exIdMode = 2'd0;
      exRegA = 7'd0; exRegB = 7'd0; exRegC = 7'd0;
      exValA = 64'd0; exValB = 64'd0; exValC = 64'd0;
      exSr = 32'd0; exFpul = 32'd0; exFpScr = 32'd0;
      set_resp(7'd0, 64'd0, 2'd0, 32'd0);
      tick(); tick();
      @(negedge clk);
      chk("rst_exHold", 64'(exHold), 64'd0);
      chk("rst_wbEn", 64'(wbEn), 64'd0);
      chk("rst_ctlWe", 64'(ctlWe), 64'd0);
      chk("rst_fpuOpMode", 64'(fpuOpMode), 64'd0);
      chk("rst_wbVal", wbVal, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(2);

      // Test 1: ADD, LAT 3, writes reg 5
      set_resp(7'd5, 64'h4000_0000_0000_0000, 2'd1, 32'h0000_0010);
      drive_cmd(OP_ADD, 2'd1, 7'd1, 7'd2, 7'd3, 64'h11, 64'h22, 64'h33, 32'h100);
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         chk("t1_exHold", 64'(exHold), 64'((c >= 1 && c <= 3) || (c == 4 && !BYP)));
         chk("t1_wbEn", 64'(wbEn), 64'(c == 4));
         if (c == 4) begin
            chk("t1_wbReg", 64'(wbReg), 64'd5);
            chk("t1_wbVal", wbVal, 64'h4000_0000_0000_0000);
         end
         @(posedge clk); #1;
         if (c == 0) clr_cmd();
      end

      // Test 2: CMPEQ, LAT 1, no FPR write, SR commit
      set_resp(ZZR, 64'hDEAD_BEEF_0000_0001, 2'd0, 32'h1);
      drive_cmd(OP_CMPEQ, 2'd0, 7'd4, 7'd6, 7'd0, 64'h5, 64'h5, 64'h0, 32'h200);
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         chk("t2_ctlWe", 64'(ctlWe), 64'(c == 2));
         chk("t2_wbEn", 64'(wbEn), 64'd0);
         if (c == 2) chk("t2_ctlOutSr", 64'(ctlOutSr), 64'h1);
         @(posedge clk); #1;
         if (c == 0) clr_cmd();
      end

      // Test 3: ADD then MUL back-to-back
      acc3 = BYP ? 4 : 5;
      wb3  = acc3 + 4;
      set_resp(7'd5, 64'h4000_0000_0000_0000, 2'd1, 32'h20);
      drive_cmd(OP_ADD, 2'd1, 7'd8, 7'd9, 7'd10, 64'hA, 64'hB, 64'hC, 32'h300);
      for (int c = 0; c <= 11; c++) begin
         @(negedge clk);
         if (c == acc3) chk("t3_accept_hold", 64'(exHold), 64'd0);
         chk("t3_wbEn", 64'(wbEn), 64'(c == 4 || c == wb3));
         if (c == wb3) chk("t3_mul_wbReg", 64'(wbReg), 64'd6);
         @(posedge clk); #1;
         if (c == 0) drive_cmd(OP_MUL, 2'd2, 7'd11, 7'd12, 7'd13, 64'h1234, 64'h5678, 64'h9ABC, 32'h400);
         if (c == 4) set_resp(7'd6, 64'hC000_1111_2222_3333, 2'd2, 32'h30);
         if (c == acc3) clr_cmd();
      end

      // Test 4: follow-on command reads the register being written back
      acc4 = BYP ? 4 : 5;
      set_resp(7'd5, 64'h3FF0_0000_0000_0000, 2'd1, 32'h40);
      drive_cmd(OP_ADD, 2'd1, 7'd1, 7'd1, 7'd1, 64'h1, 64'h1, 64'h1, 32'h500);
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         if (c == acc4 + 1) begin
            chk("t4_fpuValB", fpuValB, BYP ? 64'h3FF0_0000_0000_0000 : 64'd0);
            chk("t4_fpuValA", fpuValA, 64'h77);
         end
         @(posedge clk); #1;
         if (c == 0) drive_cmd(OP_ADD, 2'd1, 7'd2, 7'd5, 7'd3, 64'h77, 64'h0, 64'h99, 32'h600);
         if (c == 3) set_resp(7'd7, 64'h4010_0000_0000_0000, 2'd1, 32'h50);
         if (c == acc4) clr_cmd();
      end

      // Remaining opcodes, one at a time, checked by the model only
      op_list = '{OP_SUB, OP_MAC, OP_MSC, OP_CNVSI, OP_CNVIS, OP_MOV};
      for (int i = 0; i < 6; i++) begin
         set_resp((i == 3) ? ZZR : 7'(i + 20), 64'h0100_0000_0000_0000 * 64'(i + 1), 2'(i), 32'(i * 3 + 1));
         drive_cmd(op_list[i], 2'(i + 1), 7'(i + 30), 7'(i + 40), 7'(i + 50),
                   64'hAAAA_0000 + 64'(i), 64'hBBBB_0000 + 64'(i), 64'hCCCC_0000 + 64'(i), 32'(i * 16));
         tick();
         clr_cmd();
         idle(5);
      end

      // Test 6: exValid with NONE is ignored
      exValid = 1'b1; exOpMode = OP_NONE;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t6_exHold", 64'(exHold), 64'd0);
         chk("t6_wbEn", 64'(wbEn), 64'd0);
         chk("t6_ctlWe", 64'(ctlWe), 64'd0);
         chk("t6_fpuOpMode", 64'(fpuOpMode), 64'(OP_NONE));
         @(posedge clk); #1;
      end
      clr_cmd();
      idle(2);

      // Test 5: reset in the middle of a MUL
      set_resp(7'd9, 64'h5555_5555_5555_5555, 2'd3, 32'h70);
      drive_cmd(OP_MUL, 2'd3, 7'd14, 7'd15, 7'd16, 64'hF1, 64'hF2, 64'hF3, 32'h700);
      for (int c = 0; c <= 7; c++) begin
         @(negedge clk);
         if (c == 3) begin
            chk("t5_exHold", 64'(exHold), 64'd0);
            chk("t5_fpuOpMode", 64'(fpuOpMode), 64'd0);
            chk("t5_fpuValA", fpuValA, 64'd0);
            chk("t5_fpuSr", 64'(fpuSr), 64'd0);
            chk("t5_wbReg", 64'(wbReg), 64'd0);
            chk("t5_wbVal", wbVal, 64'd0);
            chk("t5_ctlOutSr", 64'(ctlOutSr), 64'd0);
         end
         chk("t5_wbEn", 64'(wbEn), 64'd0);
         chk("t5_ctlWe", 64'(ctlWe), 64'd0);
         @(posedge clk); #1;
         if (c == 0) clr_cmd();
         if (c == 1) reset = 1'b1;
         if (c == 2) reset = 1'b0;
      end

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
